// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter/sequencer for a single-port RAM.
// One access per grant: IDLE (arbitrate) -> ACCESS (RAM strobe) -> DONE (ack).
// Optional build macro: RAM_ARB_FIXED_PRIO_EN selects fixed priority (A wins)
// instead of the default round-robin pointer.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for a request; winner's we/addr/wdata latched here
// ST_ACCESS  | RAM select asserted for one cycle; read data captured
// ST_DONE    | ack pulse to the granted requester; priority handed over
module ram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  output logic          ram_sel,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_any_req;
  logic          w_grant_b;
  logic          r_gnt_b;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_a_ack;
  logic          r_b_ack;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;

  assign w_any_req = a_req | b_req;

`ifdef RAM_ARB_FIXED_PRIO_EN
  // Winner select: A always wins a tie, so B only gets in when A is quiet.
  always_comb begin
    w_grant_b = b_req & ~a_req;
  end
`else
  logic r_ptr_b;

  // Winner select: a lone requester wins, a tie goes to the pointer's choice.
  always_comb begin
    w_grant_b = (a_req & b_req) ? r_ptr_b : b_req;
  end

  // Priority pointer moves to the other requester once an access completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr_b <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_ptr_b <= ~r_gnt_b;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: ACCESS and DONE each last exactly one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any_req) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Latch the winner's command at grant so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt_b <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_gnt_b <= w_grant_b;
      r_we    <= w_grant_b ? b_we    : a_we;
      r_addr  <= w_grant_b ? b_addr  : a_addr;
      r_wdata <= w_grant_b ? b_wdata : a_wdata;
    end
  end

  // Ack pulses and read-data capture at the edge that ends ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_a_ack <= (r_state == ST_ACCESS) & ~r_gnt_b;
      r_b_ack <= (r_state == ST_ACCESS) &  r_gnt_b;
      if (r_state == ST_ACCESS && !r_we) begin
        if (r_gnt_b) begin
          r_b_rdata <= ram_dout;
        end else begin
          r_a_rdata <= ram_dout;
        end
      end
    end
  end

  // RAM strobes come straight from state; address/data hold their last grant.
  always_comb begin
    ram_sel  = (r_state == ST_ACCESS);
    ram_we   = (r_state == ST_ACCESS) & r_we;
    ram_addr = r_addr;
    ram_din  = r_wdata;
    busy     = (r_state != ST_IDLE);
    a_ack    = r_a_ack;
    b_ack    = r_b_ack;
    a_rdata  = r_a_rdata;
    b_rdata  = r_b_rdata;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM stub, transaction-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_ack, b_ack;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we, ram_sel, busy;
  logic [DW-1:0] ram_dout;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_sel(ram_sel),
    .ram_dout(ram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM stub: combinational read, write on the rising edge while selected.
  logic [DW-1:0] ram_mem [1024];
  assign ram_dout = ram_mem[ram_addr];
  always @(posedge clk) if (ram_sel && ram_we) ram_mem[ram_addr] <= ram_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one transaction at a time, tracked by its age in cycles
  // since grant (1 = RAM strobe cycle, 2 = ack cycle).
  logic [DW-1:0] sb_mem [1024];
  bit            m_on = 0;
  bit            m_act = 0;
  int            m_age = 0;
  bit            t_b, t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wd;
  bit            m_next_b = 0;
  logic [AW-1:0] m_last_addr = '0;
  logic [DW-1:0] m_last_wd = '0;
  logic [DW-1:0] m_a_rd = '0, m_b_rd = '0;

  always @(negedge clk) begin
    bit strobe, ackc;
    strobe = m_act && m_age == 1;
    ackc   = m_act && m_age == 2;
    if (m_on) begin
      chk("busy", busy, 32'(m_act));
      chk("ram_sel", ram_sel, 32'(strobe));
      chk("ram_we", ram_we, 32'(strobe && t_we));
      chk("ram_addr", ram_addr, 32'(m_last_addr));
      chk("ram_din", ram_din, m_last_wd);
      chk("a_ack", a_ack, 32'(ackc && !t_b));
      chk("b_ack", b_ack, 32'(ackc && t_b));
      chk("a_rdata", a_rdata, m_a_rd);
      chk("b_rdata", b_rdata, m_b_rd);
    end
    if (strobe) begin
      if (t_we) sb_mem[t_addr] = t_wd;
      else if (!rst) begin
        if (t_b) m_b_rd = sb_mem[t_addr];
        else     m_a_rd = sb_mem[t_addr];
      end
    end
    if (rst) begin
      m_on = 1; m_act = 0; m_age = 0; m_next_b = 0;
      m_last_addr = '0; m_last_wd = '0; m_a_rd = '0; m_b_rd = '0;
    end else if (m_act) begin
      if (m_age == 2) begin
        m_act = 0;
        m_next_b = !t_b;
      end else m_age++;
    end else if (a_req || b_req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      t_b = !a_req;
`else
      t_b = (a_req && b_req) ? m_next_b : b_req;
`endif
      t_we   = t_b ? b_we : a_we;
      t_addr = t_b ? b_addr : a_addr;
      t_wd   = t_b ? b_wdata : a_wdata;
      m_last_addr = t_addr;
      m_last_wd = t_wd;
      m_act = 1;
      m_age = 1;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One complete access by A (is_b=0) or B; returns the rdata seen with ack.
  task automatic access(input bit is_b, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rd);
    bit got;
    got = 0;
    rd = '0;
    if (is_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (is_b ? b_ack : a_ack) begin
        got = 1;
        rd = is_b ? b_rdata : a_rdata;
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL ack timeout: got no ack expected ack within 20 cycles");
    end
    @(posedge clk);
    #1;
    if (is_b) b_req = 0; else a_req = 0;
  endtask

  initial begin
    logic [DW-1:0] rd;
    int n_ack;
    bit seq [16];
    for (int i = 0; i < 1024; i++) begin ram_mem[i] = '0; sb_mem[i] = '0; end

    do_reset();
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset ram_sel", ram_sel, 0);
    chk("reset a_rdata", a_rdata, 0);
    chk("reset ram_addr", ram_addr, 0);
    @(posedge clk); #1;

    // First write: strobe one cycle after the request, ack one after that.
    a_req = 1; a_we = 1; a_addr = 5; a_wdata = 10;
    @(negedge clk);
    chk("t1 busy before grant", busy, 0);
    @(negedge clk);
    chk("t1 ram_sel", ram_sel, 1);
    chk("t1 ram_we", ram_we, 1);
    chk("t1 ram_addr", ram_addr, 5);
    chk("t1 ram_din", ram_din, 10);
    chk("t1 busy access", busy, 1);
    @(negedge clk);
    chk("t1 a_ack", a_ack, 1);
    chk("t1 busy done", busy, 1);
    @(posedge clk); #1 a_req = 0;
    @(negedge clk);
    chk("t1 a_ack after", a_ack, 0);
    chk("t1 busy after", busy, 0);
    @(posedge clk); #1;

    access(0, 0, 5, 0, rd);
    chk("t2 read back 5", rd, 10);

    // Inputs changed after grant must not affect the access.
    a_req = 1; a_we = 1; a_addr = 60; a_wdata = 32'hAA;
    @(posedge clk); #1;
    a_addr = 61; a_wdata = 32'hBB;
    @(negedge clk);
    chk("t2b latched addr", ram_addr, 60);
    chk("t2b latched data", ram_din, 32'hAA);
    @(posedge clk); #1;
    @(posedge clk); #1 a_req = 0;
    access(0, 0, 60, 0, rd);
    chk("t2b read back 60", rd, 32'hAA);

    // Both requesters held: expect A,B,A,B (or only A with fixed priority).
    do_reset();
    a_we = 1; a_addr = 100; a_wdata = 1;
    b_we = 1; b_addr = 200; b_wdata = 2;
    a_req = 1; b_req = 1;
    n_ack = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (a_ack && n_ack < 16) begin seq[n_ack] = 0; n_ack++; end
      if (b_ack && n_ack < 16) begin seq[n_ack] = 1; n_ack++; end
    end
    @(posedge clk); #1 a_req = 0; b_req = 0;
    chk("t3 ack count", n_ack, 4);
`ifdef RAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) chk("t3 fixed order", 32'(seq[i]), 0);
`else
    for (int i = 0; i < 4; i++) chk("t3 rr order", 32'(seq[i]), 32'(i % 2));
`endif
    @(posedge clk); #1;

    // Bulk load through B, read back through A, and the top address.
    for (int k = 0; k < 32; k++) access(1, 1, AW'(k), 32'(2 * k), rd);
    for (int k = 0; k < 32; k++) begin
      access(0, 0, AW'(k), 0, rd);
      chk("t4 readback", rd, 32'(2 * k));
    end
    access(0, 1, 10'd1023, 32'd1023, rd);
    access(0, 0, 10'd1023, 0, rd);
    chk("t4 addr 1023", rd, 1023);

    // Reset during the ACCESS cycle of a read.
    a_req = 1; a_we = 0; a_addr = 7;
    @(posedge clk); #1;
    rst = 1; a_req = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t5 a_ack", a_ack, 0);
    chk("t5 a_rdata", a_rdata, 0);
    chk("t5 busy", busy, 0);
    chk("t5 ram_sel", ram_sel, 0);
    @(posedge clk); #1;
    access(0, 0, 7, 0, rd);
    chk("t5 read after reset", rd, 14);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
